// File: rtl/gray_to_binary_tracker_if.sv
// Sample/result bundle of the Gray-to-binary tracker: Gray samples in, decoded
// and classified results out.
interface gray_to_binary_tracker_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]    gray_in_data;
  logic                     gray_in_valid;
  logic                     clear_err;
  logic [DATA_WIDTH-1:0]    binary_out_data;
  logic                     binary_out_valid;
  logic [1:0]               step_dir;
  logic                     step_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic                     tracking;

  modport master (
    output gray_in_data, gray_in_valid, clear_err,
    input  binary_out_data, binary_out_valid, step_dir, step_err, err_count, tracking
  );

  modport slave (
    input  gray_in_data, gray_in_valid, clear_err,
    output binary_out_data, binary_out_valid, step_dir, step_err, err_count, tracking
  );
endinterface

// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray decoder that classifies each sample against the previous one
// (hold / +1 / -1 / jump) and counts jumps in a saturating counter.
module gray_to_binary_tracker #(
  parameter int DATA_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  gray_to_binary_tracker_if.slave bus
);
  typedef enum logic {IDLE, TRACK} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    g_q, g_d;
  logic                     v1_q, v1_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic [DATA_WIDTH-1:0]    bin_q, bin_d;
  logic                     valid_q, valid_d;
  logic [1:0]               dir_q, dir_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]    b;
  logic [DATA_WIDTH-1:0]    diff;
  logic [1:0]               cls;

  always_comb begin
    g_d  = bus.gray_in_valid ? bus.gray_in_data : g_q;
    v1_d = bus.gray_in_valid;
  end

  // MSB-first prefix XOR; index counts down from the top so the loop var stays unsigned
  always_comb begin
    b = '0;
    b[DATA_WIDTH-1] = g_q[DATA_WIDTH-1];
    for (int unsigned i = 1; i < DATA_WIDTH; i++) begin
      b[DATA_WIDTH-1-i] = b[DATA_WIDTH-i] ^ g_q[DATA_WIDTH-1-i];
    end
  end

  always_comb begin
    diff = b - prev_q;
    if (diff == '0)                               cls = 2'b00;
    else if (diff == DATA_WIDTH'(1))              cls = 2'b01;
    else if (diff == {DATA_WIDTH{1'b1}})          cls = 2'b10;
    else                                          cls = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (v1_q) state_d = TRACK;
  end

  always_comb begin
    prev_d  = prev_q;
    bin_d   = bin_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    valid_d = v1_q;
    if (v1_q) begin
      prev_d = b;
      bin_d  = b;
      if (state_q == TRACK) begin
        dir_d = cls;
        err_d = (cls == 2'b11);
      end else begin
        dir_d = 2'b00;
      end
    end
  end

  // clear and a coincident error resolve to a count of one
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clear_err)       cnt_d = err_d ? ERR_CNT_WIDTH'(1) : '0;
    else if (err_d && cnt_q != '1) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q     <= '0;
      v1_q    <= 1'b0;
      prev_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      dir_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      g_q     <= g_d;
      v1_q    <= v1_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.binary_out_data  = bin_q;
  assign bus.binary_out_valid = valid_q;
  assign bus.step_dir         = dir_q;
  assign bus.step_err         = err_q;
  assign bus.err_count        = cnt_q;
  assign bus.tracking         = (state_q == TRACK);
endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker with hand-computed expectations.
module tb_gray_to_binary_tracker;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  gray_to_binary_tracker_if #(.DATA_WIDTH(16), .ERR_CNT_WIDTH(8)) bus ();

  gray_to_binary_tracker #(.DATA_WIDTH(16), .ERR_CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // drive one cycle of inputs, advance past the edge
  task automatic cyc(input logic [15:0] g, input logic v, input logic clr, input logic r);
    bus.gray_in_data  = g;
    bus.gray_in_valid = v;
    bus.clear_err     = clr;
    rst               = r;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic [15:0] data, input logic [1:0] dir,
                     input logic err, input logic [7:0] cnt);
    chk({tag, ".valid"}, 32'(bus.binary_out_valid), 32'd1);
    chk({tag, ".data"},  32'(bus.binary_out_data),  32'(data));
    chk({tag, ".dir"},   32'(bus.step_dir),         32'(dir));
    chk({tag, ".err"},   32'(bus.step_err),         32'(err));
    chk({tag, ".cnt"},   32'(bus.err_count),        32'(cnt));
  endtask

  initial begin
    logic [15:0] g;
    // reset
    cyc(16'h1234, 1'b1, 1'b1, 1'b1);
    cyc(16'h0, 1'b0, 1'b0, 1'b1);
    chk("rst.valid", 32'(bus.binary_out_valid), 32'd0);
    chk("rst.data",  32'(bus.binary_out_data),  32'd0);
    chk("rst.dir",   32'(bus.step_dir),         32'd0);
    chk("rst.err",   32'(bus.step_err),         32'd0);
    chk("rst.cnt",   32'(bus.err_count),        32'd0);
    chk("rst.trk",   32'(bus.tracking),         32'd0);

    // first sample then +1, back-to-back
    cyc(16'h39DD, 1'b1, 1'b0, 1'b0);
    chk("t1.trk0", 32'(bus.tracking), 32'd0);
    cyc(16'h39DC, 1'b1, 1'b0, 1'b0);
    out("t1.first", 16'h2E96, 2'b00, 1'b0, 8'd0);
    chk("t1.trk1", 32'(bus.tracking), 32'd1);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    out("t1.up", 16'h2E97, 2'b01, 1'b0, 8'd0);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    chk("t1.gap.valid", 32'(bus.binary_out_valid), 32'd0);
    chk("t1.gap.hold",  32'(bus.binary_out_data),  32'h2E97);
    chk("t1.gap.dir",   32'(bus.step_dir),         32'd1);

    // wrap-around up and down
    cyc(16'h0, 1'b0, 1'b0, 1'b1);
    cyc(16'h8000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    out("t2.ref", 16'hFFFF, 2'b00, 1'b0, 8'd0);
    cyc(16'h8000, 1'b1, 1'b0, 1'b0);
    out("t2.wrapup", 16'h0000, 2'b01, 1'b0, 8'd0);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    out("t2.wrapdn", 16'hFFFF, 2'b10, 1'b0, 8'd0);

    // jump then reference follows the jump
    cyc(16'h0, 1'b0, 1'b0, 1'b1);
    cyc(16'h39DD, 1'b1, 1'b0, 1'b0);
    cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0001, 1'b1, 1'b0, 1'b0);
    out("t3.jump", 16'h0000, 2'b11, 1'b1, 8'd1);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    out("t3.after", 16'h0001, 2'b01, 1'b0, 8'd1);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    chk("t3.errlow", 32'(bus.step_err), 32'd0);

    // 300 alternating jumps from reference 0x0001: count saturates
    for (int i = 0; i < 300; i++) begin
      g = (i % 2 == 0) ? 16'h39DD : 16'h0000;
      cyc(g, 1'b1, 1'b0, 1'b0);
    end
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    out("t4.sat", 16'h0000, 2'b11, 1'b1, 8'd255);
    cyc(16'h0, 1'b0, 1'b1, 1'b0);
    chk("t4.clr", 32'(bus.err_count), 32'd0);
    cyc(16'h39DD, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b1, 1'b0);
    out("t4.clrjump", 16'h2E96, 2'b11, 1'b1, 8'd1);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    chk("t4.hold", 32'(bus.err_count), 32'd1);

    // reset with two samples in flight
    cyc(16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(16'h0003, 1'b1, 1'b0, 1'b1);
    chk("t5.valid", 32'(bus.binary_out_valid), 32'd0);
    chk("t5.trk",   32'(bus.tracking),         32'd0);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    chk("t5.valid2", 32'(bus.binary_out_valid), 32'd0);
    cyc(16'h39DD, 1'b1, 1'b0, 1'b0);
    cyc(16'h0, 1'b0, 1'b0, 1'b0);
    out("t5.first", 16'h2E96, 2'b00, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
